// File: rtl/clic_nest_ctrl.sv
// CLIC interrupt nesting controller: accepts eligible CLIC requests, drains the
// pipeline, acknowledges, and tracks preempted contexts on a LIFO level stack.
module clic_nest_ctrl #(
    parameter  int N_SOURCE     = 256,
    parameter  int NEST_DEPTH   = 4,
    parameter  int DRAIN_CYCLES = 3,
    localparam int SRC_W        = $clog2(N_SOURCE),
    localparam int DEP_W        = $clog2(NEST_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clic_irq_valid_i,
    output logic             clic_irq_ready_o,
    input  logic [SRC_W-1:0] clic_irq_id_i,
    input  logic [7:0]       clic_irq_level_i,
    input  logic             clic_irq_shv_i,
    input  logic [1:0]       clic_irq_priv_i,
    input  logic             irq_en_i,
    input  logic [7:0]       threshold_i,
    input  logic             mret_i,
    output logic             flush_o,
    output logic             take_o,
    output logic [SRC_W-1:0] take_id_o,
    output logic             take_shv_o,
    output logic [1:0]       take_priv_o,
    output logic [7:0]       cur_level_o,
    output logic [1:0]       cur_priv_o,
    output logic [DEP_W-1:0] depth_o,
    output logic             err_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DEP_W-1:0] DEPTH_MAX = DEP_W'(NEST_DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, DRAIN, ACK} state_t;

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic [7:0]       lat_level;
    logic             ret_pending;
    logic [9:0]       stack [NEST_DEPTH];

    logic [DEP_W-1:0] depth_m1;
    logic [9:0]       top_entry;
    logic             eligible;
    logic             can_pop;
    logic             pop_req;

    assign depth_m1  = depth_o - DEP_W'(1);
    assign top_entry = stack[depth_m1[IDX_W-1:0]];
    assign can_pop   = (depth_o != '0);

    assign eligible = clic_irq_valid_i & irq_en_i
                    & (clic_irq_level_i > cur_level_o)
                    & (clic_irq_level_i > threshold_i)
                    & (depth_o < DEPTH_MAX);

    // A handler return deferred from ACK is serviced first, ahead of both a new mret and any accept.
    assign pop_req = ((state == IDLE) & (ret_pending | mret_i))
                   | ((state == DRAIN) & mret_i);

    // Stack contents need no reset; only depth_o says which entries are live.
    always_ff @(posedge clk_i) begin
        if (state == ACK) begin
            stack[depth_o[IDX_W-1:0]] <= {cur_level_o, cur_priv_o};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            drain_cnt        <= '0;
            lat_level        <= '0;
            ret_pending      <= 1'b0;
            clic_irq_ready_o <= 1'b0;
            take_o           <= 1'b0;
            flush_o          <= 1'b0;
            take_id_o        <= '0;
            take_shv_o       <= 1'b0;
            take_priv_o      <= '0;
            cur_level_o      <= '0;
            cur_priv_o       <= 2'b11;
            depth_o          <= '0;
            err_o            <= 1'b0;
        end else begin
            if (pop_req) begin
                if (can_pop) begin
                    cur_level_o <= top_entry[9:2];
                    cur_priv_o  <= top_entry[1:0];
                    depth_o     <= depth_m1;
                end else begin
                    err_o <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ret_pending) begin
                        ret_pending <= 1'b0;
                    end else if (!mret_i && eligible) begin
                        take_id_o   <= clic_irq_id_i;
                        take_shv_o  <= clic_irq_shv_i;
                        take_priv_o <= clic_irq_priv_i;
                        lat_level   <= clic_irq_level_i;
                        if (DRAIN_CYCLES == 0) begin
                            state            <= ACK;
                            clic_irq_ready_o <= 1'b1;
                            take_o           <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= CNT_INIT;
                            flush_o   <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (mret_i || !eligible) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                    end else if (drain_cnt == '0) begin
                        state            <= ACK;
                        flush_o          <= 1'b0;
                        clic_irq_ready_o <= 1'b1;
                        take_o           <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    state            <= IDLE;
                    clic_irq_ready_o <= 1'b0;
                    take_o           <= 1'b0;
                    cur_level_o      <= lat_level;
                    cur_priv_o       <= take_priv_o;
                    depth_o          <= depth_o + DEP_W'(1);
                    if (mret_i) begin
                        ret_pending <= 1'b1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    clic_irq_ready_o <= 1'b0;
                    take_o           <= 1'b0;
                    flush_o          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clic_nest_ctrl.sv
// Self-checking bench for clic_nest_ctrl: directed nesting scenarios plus a
// randomized run, all compared cycle by cycle against a queue-based context model.
module tb_clic_nest_ctrl;

    localparam int ND    = 4;
    localparam int DC    = 3;
    localparam int SRC_W = 8;
    localparam int DEP_W = 3;
    localparam int OBS_W = 3 + 8 + 2 + DEP_W + 1 + SRC_W + 1 + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             irq_valid;
    logic             irq_ready;
    logic [SRC_W-1:0] irq_id;
    logic [7:0]       irq_level;
    logic             irq_shv;
    logic [1:0]       irq_priv;
    logic             irq_en;
    logic [7:0]       threshold;
    logic             mret;
    logic             flush;
    logic             take;
    logic [SRC_W-1:0] take_id;
    logic             take_shv;
    logic [1:0]       take_priv;
    logic [7:0]       cur_level;
    logic [1:0]       cur_priv;
    logic [DEP_W-1:0] depth;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;

    clic_nest_ctrl #(.N_SOURCE(256), .NEST_DEPTH(ND), .DRAIN_CYCLES(DC)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .clic_irq_valid_i (irq_valid),
        .clic_irq_ready_o (irq_ready),
        .clic_irq_id_i    (irq_id),
        .clic_irq_level_i (irq_level),
        .clic_irq_shv_i   (irq_shv),
        .clic_irq_priv_i  (irq_priv),
        .irq_en_i         (irq_en),
        .threshold_i      (threshold),
        .mret_i           (mret),
        .flush_o          (flush),
        .take_o           (take),
        .take_id_o        (take_id),
        .take_shv_o       (take_shv),
        .take_priv_o      (take_priv),
        .cur_level_o      (cur_level),
        .cur_priv_o       (cur_priv),
        .depth_o          (depth),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    // Reference model: running context, a queue of preempted contexts, and the
    // in-flight request measured by its age in cycles since acceptance.
    typedef struct packed {
        logic [7:0] lvl;
        logic [1:0] priv;
    } ctx_t;

    ctx_t             m_stack[$];
    logic [7:0]       m_lvl;
    logic [1:0]       m_priv;
    bit               m_err;
    bit               m_retp;
    bit               m_busy;
    int               m_age;
    logic [SRC_W-1:0] m_id;
    logic             m_shv;
    logic [1:0]       m_rpriv;
    logic [7:0]       m_rlvl;

    function automatic void model_reset();
        m_stack.delete();
        m_lvl  = 8'd0;
        m_priv = 2'b11;
        m_err  = 1'b0;
        m_retp = 1'b0;
        m_busy = 1'b0;
        m_age  = 0;
    endfunction

    function automatic void model_pop();
        ctx_t c;
        if (m_stack.size() > 0) begin
            c      = m_stack.pop_back();
            m_lvl  = c.lvl;
            m_priv = c.priv;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_step();
        bit elig;
        elig = irq_valid && irq_en && (irq_level > m_lvl) && (irq_level > threshold)
               && (m_stack.size() < ND);
        if (!m_busy) begin
            if (m_retp) begin
                model_pop();
                m_retp = 1'b0;
            end else if (mret) begin
                model_pop();
            end else if (elig) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_id    = irq_id;
                m_shv   = irq_shv;
                m_rpriv = irq_priv;
                m_rlvl  = irq_level;
            end
        end else if (m_age <= DC) begin
            if (mret) begin
                m_busy = 1'b0;
                model_pop();
            end else if (!elig) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end else begin
            m_stack.push_back('{lvl: m_lvl, priv: m_priv});
            m_lvl  = m_rlvl;
            m_priv = m_rpriv;
            m_busy = 1'b0;
            if (mret) m_retp = 1'b1;
        end
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        bit ack;
        bit drn;
        ack = m_busy && (m_age == DC + 1);
        drn = m_busy && (m_age <= DC);
        return {ack, ack, drn, m_lvl, m_priv, DEP_W'(m_stack.size()), m_err,
                ack ? {m_id, m_shv, m_rpriv} : {(SRC_W + 3){1'b0}}};
    endfunction

    function automatic logic [OBS_W-1:0] dut_obs();
        return {irq_ready, take, flush, cur_level, cur_priv, depth, err,
                take ? {take_id, take_shv, take_priv} : {(SRC_W + 3){1'b0}}};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        irq_valid = 1'b0;
        mret      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if ({irq_ready, take, flush} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes got %b want 000", {irq_ready, take, flush});
        end
        vectors++;
        if (cur_level !== 8'd0 || cur_priv !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL reset_ctx got lvl=%0d priv=%b want lvl=0 priv=11", cur_level, cur_priv);
        end
        vectors++;
        if (depth !== '0 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_depth_err got depth=%0d err=%b want 0 0", depth, err);
        end
        vectors++;
        if ({take_id, take_shv, take_priv} !== {(SRC_W + 3){1'b0}}) begin
            miscompares++;
            $display("[TB] FAIL reset_take_attr got %h want 0", {take_id, take_shv, take_priv});
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_basic();
        int nflush = 0;
        int rdy_cyc = -1;
        do_reset();
        irq_en    = 1'b1;
        threshold = 8'd0;
        irq_valid = 1'b1;
        irq_id    = 8'd5;
        irq_level = 8'd8;
        irq_shv   = 1'b1;
        irq_priv  = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL basic cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (flush) nflush++;
            if (irq_ready && rdy_cyc < 0) rdy_cyc = c;
            if (irq_ready) irq_valid = 1'b0;
        end
        vectors++;
        if (nflush != DC || rdy_cyc != DC + 1) begin
            miscompares++;
            $display("[TB] FAIL basic_latency got flush=%0d ready_cyc=%0d want %0d %0d",
                     nflush, rdy_cyc, DC, DC + 1);
        end
        vectors++;
        if (cur_level !== 8'd8 || depth !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL basic_level got lvl=%0d depth=%0d want 8 1", cur_level, depth);
        end
    endtask

    task automatic test_preempt();
        int nready = 0;
        irq_valid = 1'b1;
        irq_level = 8'd8;
        irq_id    = 8'd8;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL preempt_same cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (irq_ready) nready++;
        end
        irq_level = 8'd9;
        irq_id    = 8'd9;
        irq_priv  = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL preempt_higher cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (irq_ready) begin
                nready++;
                irq_valid = 1'b0;
            end
        end
        vectors++;
        if (nready != 1 || cur_level !== 8'd9 || depth !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL preempt_take got acks=%0d lvl=%0d depth=%0d want 1 9 2",
                     nready, cur_level, depth);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        vectors++;
        if (cur_level !== 8'd8 || cur_priv !== 2'b01 || depth !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL preempt_mret got lvl=%0d priv=%b depth=%0d want 8 01 1",
                     cur_level, cur_priv, depth);
        end
    endtask

    task automatic test_abort();
        bit saw_ready = 1'b0;
        irq_valid = 1'b1;
        irq_level = 8'd10;
        irq_id    = 8'd10;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) irq_valid = 1'b0;
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL abort cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (irq_ready) saw_ready = 1'b1;
        end
        vectors++;
        if (saw_ready || flush !== 1'b0 || cur_level !== 8'd8 || depth !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL abort_state got ready=%b flush=%b lvl=%0d depth=%0d want 0 0 8 1",
                     saw_ready, flush, cur_level, depth);
        end
    endtask

    task automatic test_full();
        bit saw_ready = 1'b0;
        do_reset();
        for (int l = 1; l <= ND; l++) begin
            irq_valid = 1'b1;
            irq_level = 8'(l);
            irq_id    = 8'(l);
            for (int c = 0; c < DC + 3; c++) begin
                tick();
                vectors++;
                if (dut_obs() !== model_obs()) begin
                    miscompares++;
                    $display("[TB] FAIL full_fill lvl %0d cyc %0d got %h want %h",
                             l, c, dut_obs(), model_obs());
                end
                if (irq_ready) irq_valid = 1'b0;
            end
        end
        vectors++;
        if (depth !== 3'(ND) || cur_level !== 8'(ND)) begin
            miscompares++;
            $display("[TB] FAIL full_depth got depth=%0d lvl=%0d want %0d %0d", depth, cur_level, ND, ND);
        end
        irq_valid = 1'b1;
        irq_level = 8'(ND + 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL full_hold cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (irq_ready || flush) saw_ready = 1'b1;
        end
        vectors++;
        if (saw_ready || depth !== 3'(ND) || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_holdoff got busy=%b depth=%0d err=%b want 0 %0d 0",
                     saw_ready, depth, err, ND);
        end
        irq_valid = 1'b0;
    endtask

    task automatic test_mret();
        bit got_ack = 1'b0;
        do_reset();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (err !== 1'b1 || depth !== '0) begin
                miscompares++;
                $display("[TB] FAIL mret_underflow cyc %0d got err=%b depth=%0d want 1 0", c, err, depth);
            end
        end
        irq_valid = 1'b1;
        irq_level = 8'd3;
        irq_id    = 8'd33;
        for (int c = 0; c < 10 && !got_ack; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL mret_take cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (take) begin
                got_ack   = 1'b1;
                irq_valid = 1'b0;
                mret      = 1'b1;
            end
        end
        vectors++;
        if (!got_ack) begin
            miscompares++;
            $display("[TB] FAIL mret_take_timeout got no take within 10 cycles want take");
        end
        tick();
        mret = 1'b0;
        vectors++;
        if (cur_level !== 8'd3 || depth !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL mret_in_ack_push got lvl=%0d depth=%0d want 3 1", cur_level, depth);
        end
        tick();
        vectors++;
        if (cur_level !== 8'd0 || cur_priv !== 2'b11 || depth !== '0 || err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mret_in_ack_pop got lvl=%0d priv=%b depth=%0d err=%b want 0 11 0 1",
                     cur_level, cur_priv, depth, err);
        end
    endtask

    task automatic test_reset_drain();
        bit saw_ready = 1'b0;
        do_reset();
        irq_valid = 1'b1;
        irq_level = 8'd5;
        irq_id    = 8'd7;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (dut_obs() !== model_obs() || {take_id, take_shv, take_priv} !== {(SRC_W + 3){1'b0}}) begin
            miscompares++;
            $display("[TB] FAIL reset_in_drain got %h want %h", dut_obs(), model_obs());
        end
        irq_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL reset_after cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
            if (irq_ready) saw_ready = 1'b1;
        end
        vectors++;
        if (saw_ready) begin
            miscompares++;
            $display("[TB] FAIL reset_no_ready got ready pulse want none");
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 750 == 749) do_reset();
            if (irq_valid && irq_ready) begin
                irq_valid = 1'b0;
            end else if (irq_valid && $urandom_range(19) == 0) begin
                irq_valid = 1'b0;
            end else if (!irq_valid && $urandom_range(2) == 0) begin
                irq_valid = 1'b1;
                irq_id    = 8'($urandom);
                irq_level = 8'($urandom_range(15));
                irq_shv   = 1'($urandom);
                irq_priv  = 2'($urandom);
            end
            irq_en    = ($urandom_range(9) != 0);
            threshold = 8'($urandom_range(5));
            mret      = ($urandom_range(11) == 0);
            tick();
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("[TB] FAIL random cyc %0d got %h want %h", c, dut_obs(), model_obs());
            end
        end
        mret      = 1'b0;
        irq_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        irq_valid = 1'b0;
        irq_id    = '0;
        irq_level = '0;
        irq_shv   = 1'b0;
        irq_priv  = '0;
        irq_en    = 1'b1;
        threshold = '0;
        mret      = 1'b0;
        model_reset();

        test_reset();
        test_basic();
        test_preempt();
        test_abort();
        test_full();
        test_mret();
        test_reset_drain();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clic_nest_ctrl.md
CLIC_NEST_CTRL -- requirements
Module: clic_nest_ctrl

Interface
REQ-001 SHALL have parameter N_SOURCE, default 256, number of CLIC interrupt sources.
REQ-002 SHALL have parameter NEST_DEPTH, default 4, max preemption nesting levels held in the level stack.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, pipeline drain cycles between accept and acknowledge (0 legal).
REQ-004 SHALL derive SRC_W = $clog2(N_SOURCE) and DEP_W = $clog2(NEST_DEPTH+1).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 clic_irq_valid_i  in  1  CLIC request valid; held until ready.
REQ-009 clic_irq_ready_o  out  1  one-cycle acknowledge.
REQ-010 clic_irq_id_i  in  SRC_W  interrupt ID.
REQ-011 clic_irq_level_i  in  8  interrupt level.
REQ-012 clic_irq_shv_i  in  1  vectored mode.
REQ-013 clic_irq_priv_i  in  2  interrupt privilege.
REQ-014 irq_en_i  in  1  global interrupt enable.
REQ-015 threshold_i  in  8  level threshold.
REQ-016 mret_i  in  1  handler-return pulse.
REQ-017 flush_o  out  1  pipeline flush request during drain.
REQ-018 take_o  out  1  one-cycle pulse, interrupt taken.
REQ-019 take_id_o / take_shv_o / take_priv_o  out  SRC_W/1/2  latched attributes, valid with take_o.
REQ-020 cur_level_o  out  8  level of running handler.
REQ-021 cur_priv_o  out  2  privilege of running context.
REQ-022 depth_o  out  DEP_W  stack occupancy.
REQ-023 err_o  out  1  sticky mret-underflow flag.

Function
REQ-024 eligible SHALL = valid & irq_en_i & (level > cur_level) & (level > threshold_i) & (depth < NEST_DEPTH), unsigned compares.
REQ-025 FSM states IDLE, DRAIN, ACK; reset state IDLE.
REQ-026 IDLE: eligible & !mret_i -> latch id/level/shv/priv; go DRAIN with counter=DRAIN_CYCLES-1, or ACK if DRAIN_CYCLES=0.
REQ-027 DRAIN: flush_o=1; if !eligible (recomputed with live inputs) -> IDLE, no ack, latched data discarded.
REQ-028 DRAIN: else counter==0 -> ACK, otherwise counter decrements; latency accept-to-ready = DRAIN_CYCLES+1 cycles.
REQ-029 ACK: clic_irq_ready_o=1 and take_o=1 same cycle; push {cur_level,cur_priv}; cur_level<=latched level; cur_priv<=latched priv; depth+1; -> IDLE.
REQ-030 ready_o and take_o SHALL be asserted only in ACK, exactly one cycle per accepted interrupt.
REQ-031 mret_i in IDLE with depth>0: pop top into cur_level/cur_priv, depth-1, same cycle wins over accept (no accept that cycle).
REQ-032 mret_i in IDLE with depth==0: no state change, err_o<=1 (sticky until reset).
REQ-033 mret_i in DRAIN: abort to IDLE (no ack) and perform REQ-031/032 pop in that cycle.
REQ-034 mret_i in ACK: set pending-return flag; executed as a pop in next IDLE cycle before any accept; flag cleared then.
REQ-035 depth==NEST_DEPTH SHALL hold off new requests (valid stays unacknowledged), no error.
REQ-036 Stack SHALL be LIFO of NEST_DEPTH entries, 10 bits each, no wrap.

Reset
REQ-037 On rst_i: state IDLE, counter 0, ready_o/take_o/flush_o 0, take_* 0, cur_level_o 0, cur_priv_o 2'b11, depth_o 0, err_o 0, pending flag 0, stack contents don't-care.
REQ-038 rst_i asserted mid-DRAIN or ACK SHALL abort immediately; no ready pulse after reset release without fresh eligibility.

Verification
REQ-039 DRAIN_CYCLES=3, en=1, thr=0, valid id=5 level=8 -> flush_o 3 cycles, ready_o+take_o on 4th cycle after accept, cur_level_o=8, depth_o=1.
REQ-040 Running level 8, request level 8 then level 9 -> level 8 never acked; level 9 taken, depth_o=2; mret_i -> cur_level_o=8, depth_o=1.
REQ-041 valid dropped in 2nd DRAIN cycle -> FSM back to IDLE, no ready_o, cur_level_o/depth_o unchanged.
REQ-042 NEST_DEPTH=4, four nested takes levels 1..4, request level 5 -> held, ready_o stays 0, depth_o=4.
REQ-043 mret_i at depth 0 -> err_o=1 and stays 1; mret_i asserted during ACK -> take_o pulses, next cycle pop restores previous level.
REQ-044 rst_i pulsed during DRAIN -> all outputs at REQ-037 values next edge, no ready_o afterward with valid low.
